// File: rtl/lc3_writeback_if.sv
// Writeback-stage bus: pipeline inputs into the register file and operand/status outputs back out.
interface lc3_writeback_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] npc_in;
  logic [1:0]        W_Control_in;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] pcout;
  logic [DATA_W-1:0] memout;
  logic              enable_writeback;
  logic [2:0]        sr1;
  logic [2:0]        sr2;
  logic [2:0]        dr;
  logic [DATA_W-1:0] VSR1;
  logic [DATA_W-1:0] VSR2;
  logic [2:0]        psr;
  logic [DATA_W-1:0] wb_value;

  modport master (
    output npc_in, W_Control_in, aluout, pcout, memout,
    output enable_writeback, sr1, sr2, dr,
    input  VSR1, VSR2, psr, wb_value
  );

  modport slave (
    input  npc_in, W_Control_in, aluout, pcout, memout,
    input  enable_writeback, sr1, sr2, dr,
    output VSR1, VSR2, psr, wb_value
  );
endinterface

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: 8x16 register file plus N/Z/P condition codes.
// Optional macro LC3_WB_BYPASS_EN forwards the same-cycle writeback value onto VSR1/VSR2.
module lc3_writeback #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [2:0]  PSR_RST  = 3'b000
) (
  input logic            clock,
  input logic            reset,
  lc3_writeback_if.slave wb
);

  if (DATA_W != 16) begin : g_width_check
    $error("lc3_writeback supports DATA_W=16 only");
  end

  logic [DATA_W-1:0] regFile_q [NUM_REGS];
  logic [2:0]        psr_q;
  logic [2:0]        psr_d;
  logic [DATA_W-1:0] wbValue;

  always_comb begin
    wbValue = wb.aluout;
    case (wb.W_Control_in)
      2'd0: wbValue = wb.aluout;
      2'd1: wbValue = wb.memout;
      2'd2: wbValue = wb.pcout;
      2'd3: wbValue = wb.npc_in;
    endcase
  end

  always_comb begin
    if (wbValue[DATA_W-1]) begin
      psr_d = 3'b100;
    end else if (wbValue == '0) begin
      psr_d = 3'b010;
    end else begin
      psr_d = 3'b001;
    end
  end

  // State changes only under enable, so X on idle data inputs never reaches the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regFile_q[i] <= '0;
      end
      psr_q <= PSR_RST;
    end else if (wb.enable_writeback) begin
      regFile_q[wb.dr] <= wbValue;
      psr_q            <= psr_d;
    end
  end

`ifdef LC3_WB_BYPASS_EN
  assign wb.VSR1 = (wb.enable_writeback && !reset && (wb.sr1 == wb.dr)) ? wbValue : regFile_q[wb.sr1];
  assign wb.VSR2 = (wb.enable_writeback && !reset && (wb.sr2 == wb.dr)) ? wbValue : regFile_q[wb.sr2];
`else
  assign wb.VSR1 = regFile_q[wb.sr1];
  assign wb.VSR2 = regFile_q[wb.sr2];
`endif

  assign wb.psr      = psr_q;
  assign wb.wb_value = wbValue;

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed scenarios with literal expectations,
// then random traffic compared every cycle against a register-array reference model.
module tb_lc3_writeback;

  localparam logic [2:0] PSR_RST = 3'b000;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  lc3_writeback_if #(.DATA_W(16)) bus ();

  lc3_writeback #(
    .DATA_W  (16),
    .NUM_REGS(8),
    .PSR_RST (PSR_RST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wb   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a plain array of registers and a condition-code value.
  logic [15:0] modelR [8];
  logic [2:0]  modelPsr;
  bit          modelValid;

  function automatic logic [15:0] selectValue(logic [1:0] sel, logic [15:0] alu, logic [15:0] mem,
                                              logic [15:0] pc, logic [15:0] npc);
    logic [15:0] choices [4];
    choices[0] = alu;
    choices[1] = mem;
    choices[2] = pc;
    choices[3] = npc;
    return choices[sel];
  endfunction

  function automatic logic [2:0] condCodes(logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(posedge clock) begin
    logic [15:0] v;
    if (reset) begin
      for (int i = 0; i < 8; i++) modelR[i] = 16'h0000;
      modelPsr   = PSR_RST;
      modelValid = 1'b1;
    end else if (bus.enable_writeback) begin
      v = selectValue(bus.W_Control_in, bus.aluout, bus.memout, bus.pcout, bus.npc_in);
      modelR[bus.dr] = v;
      modelPsr       = condCodes(v);
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clock) begin
    logic [15:0] expWb;
    logic [15:0] exp1;
    logic [15:0] exp2;
    if (modelValid) begin
      expWb = selectValue(bus.W_Control_in, bus.aluout, bus.memout, bus.pcout, bus.npc_in);
      exp1  = modelR[bus.sr1];
      exp2  = modelR[bus.sr2];
`ifdef LC3_WB_BYPASS_EN
      if (bus.enable_writeback && !reset && bus.sr1 == bus.dr) exp1 = expWb;
      if (bus.enable_writeback && !reset && bus.sr2 == bus.dr) exp2 = expWb;
`endif
      checkOutput("model_wb_value", bus.wb_value, expWb);
      checkOutput("model_VSR1", bus.VSR1, exp1);
      checkOutput("model_VSR2", bus.VSR2, exp2);
      checkOutput("model_psr", {13'b0, bus.psr}, {13'b0, modelPsr});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit en, input logic [1:0] sel, input logic [2:0] d,
                               input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] alu);
    bus.enable_writeback = en;
    bus.W_Control_in     = sel;
    bus.dr               = d;
    bus.sr1              = s1;
    bus.sr2              = s2;
    bus.aluout           = alu;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] srcExp [4];
    logic [2:0]  psrExp [4];
    logic [15:0] vExp;
    checks     = 0;
    errors     = 0;
    modelValid = 1'b0;
    reset      = 1'b1;
    bus.npc_in = 16'h0000;
    bus.pcout  = 16'h0000;
    bus.memout = 16'h0000;
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    tick();
    tick();
    reset = 1'b0;

    // R3 = 1234, then reset for two cycles clears it.
    applyStimulus(1'b1, 2'd0, 3'd3, 3'd3, 3'd3, 16'h1234);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd3, 3'd3, 3'd3, 16'h0000);
    @(negedge clock);
    checkOutput("r3_written", bus.VSR1, 16'h1234);
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("reset_r3", bus.VSR1, 16'h0000);
    checkOutput("reset_psr", {13'b0, bus.psr}, {13'b0, PSR_RST});
    tick();

    // Source select through all four encodings into R5.
    srcExp = '{16'h0011, 16'h8000, 16'h3000, 16'h3001};
    psrExp = '{3'b001, 3'b100, 3'b001, 3'b001};
    bus.memout = 16'h8000;
    bus.pcout  = 16'h3000;
    bus.npc_in = 16'h3001;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), 3'd5, 3'd5, 3'd1, 16'h0011);
      @(negedge clock);
      checkOutput("select_wb_value", bus.wb_value, srcExp[k]);
      if (k > 0) begin
        checkOutput("select_psr", {13'b0, bus.psr}, {13'b0, psrExp[k-1]});
`ifdef LC3_WB_BYPASS_EN
        vExp = srcExp[k];
`else
        vExp = srcExp[k-1];
`endif
        checkOutput("select_VSR1", bus.VSR1, vExp);
      end
      tick();
    end
    applyStimulus(1'b0, 2'd0, 3'd5, 3'd5, 3'd1, 16'h0000);
    @(negedge clock);
    checkOutput("select_final_r5", bus.VSR1, 16'h3001);
    checkOutput("select_final_psr", {13'b0, bus.psr}, 16'h0001);
    tick();

    // Zero result into R0 (R0 is an ordinary register).
    applyStimulus(1'b1, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    @(negedge clock);
    checkOutput("zero_r0", bus.VSR1, 16'h0000);
    checkOutput("zero_psr", {13'b0, bus.psr}, 16'h0002);
    tick();

    // Disabled write leaves R2 and psr alone.
    applyStimulus(1'b0, 2'd0, 3'd2, 3'd2, 3'd2, 16'hFFFF);
    tick();
    @(negedge clock);
    checkOutput("disabled_r2", bus.VSR1, 16'h0000);
    checkOutput("disabled_psr", {13'b0, bus.psr}, 16'h0002);
    tick();

    // Read and write R7 in the same cycle.
    applyStimulus(1'b1, 2'd0, 3'd7, 3'd0, 3'd0, 16'h0001);
    tick();
    applyStimulus(1'b1, 2'd0, 3'd7, 3'd7, 3'd7, 16'hABCD);
    @(negedge clock);
`ifdef LC3_WB_BYPASS_EN
    vExp = 16'hABCD;
`else
    vExp = 16'h0001;
`endif
    checkOutput("rw_same_VSR1", bus.VSR1, vExp);
    checkOutput("rw_same_VSR2", bus.VSR2, vExp);
    tick();
    applyStimulus(1'b0, 2'd0, 3'd7, 3'd7, 3'd7, 16'h0000);
    @(negedge clock);
    checkOutput("rw_next_VSR1", bus.VSR1, 16'hABCD);
    checkOutput("rw_next_VSR2", bus.VSR2, 16'hABCD);
    checkOutput("rw_next_psr", {13'b0, bus.psr}, 16'h0004);
    tick();

    // Reset wins over a simultaneous write.
    applyStimulus(1'b1, 2'd0, 3'd4, 3'd4, 3'd4, 16'h7777);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 2'd0, 3'd4, 3'd4, 3'd4, 16'h5555);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 3'd4, 3'd4, 3'd4, 16'h0000);
    @(negedge clock);
    checkOutput("reset_vs_write_r4", bus.VSR1, 16'h0000);
    checkOutput("reset_vs_write_psr", {13'b0, bus.psr}, {13'b0, PSR_RST});
    tick();

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 24) == 0);
      bus.npc_in = 16'($urandom);
      bus.pcout  = 16'($urandom);
      bus.memout = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom));
      tick();
    end
    reset = 1'b0;
    bus.enable_writeback = 1'b0;
    tick();
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
Name: lc3_writeback

Overview:
- Writeback stage of the LC3 pipeline. Consumes the writeback_in bus: npc_in, W_Control_in, aluout, pcout, memout, enable_writeback, sr1, sr2, dr.
- Holds the 8x16 general-purpose register file and the PSR condition codes.
- Selects the writeback value, writes it to register dr and updates N/Z/P.
- Supplies source operands VSR1/VSR2 to the Execute stage.

Parameters:
- DATA_W, 16, register and datapath width. Only 16 is supported; a generate-time check errors on any other value.
- NUM_REGS, 8, register count. Fixed by the 3-bit sr1/sr2/dr fields.
- PSR_RST, 3'b000, reset value of psr.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- npc_in  input  16  next PC of the instruction in writeback
- W_Control_in  input  2  writeback source select
- aluout  input  16  Execute result
- pcout  input  16  computed PC/address result
- memout  input  16  memory read data
- enable_writeback  input  1  stage enable; a write occurs only when high
- sr1  input  3  source register 1 address
- sr2  input  3  source register 2 address
- dr  input  3  destination register address
- VSR1  output  16  contents of R[sr1]
- VSR2  output  16  contents of R[sr2]
- psr  output  3  condition codes {N,Z,P}, registered
- wb_value  output  16  selected writeback value, combinational debug/observe port

Behaviour:
- Interface (already decided): one clock, named clock. Reset is named reset and is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset: on a clock edge with reset=1, R0..R7 <= 16'h0000 and psr <= PSR_RST. Reset overrides enable_writeback in the same cycle. Reset asserted mid-stream discards any pending write.
- Source select (combinational), producing wb_value:
  - W_Control_in=0 -> aluout
  - W_Control_in=1 -> memout
  - W_Control_in=2 -> pcout
  - W_Control_in=3 -> npc_in
- Write: on a rising edge with reset=0 and enable_writeback=1:
  - R[dr] <= wb_value.
  - psr <= 3'b100 if wb_value[15]=1; 3'b010 if wb_value==0; 3'b001 otherwise.
  - Latency: 1 cycle. The new value is visible on VSR1/VSR2 and psr starting the cycle after the edge.
- Hold: with enable_writeback=0 the register file and psr hold, and the inputs are don't-care. X on data inputs while disabled must not propagate into state.
- Read: VSR1 = R[sr1] and VSR2 = R[sr2], combinational from stored contents. With the bypass macro undefined, these show the pre-write value in the same cycle as a write to that register.
- All 8 registers, R0 included, are writable. There is no hardwired zero register.
- sr1==sr2 is legal: both outputs show the same register.
- Back-to-back writes to the same dr on consecutive cycles: the last write wins, and psr reflects each write in turn.
- Illegal values: none. All 2-bit and 3-bit encodings are defined.
- Outputs during reset: VSR1/VSR2 reflect the register contents; they are 0 from the cycle after the reset edge. psr=PSR_RST.

Optional Feature:
- Macro: LC3_WB_BYPASS_EN
- Defined:
  - If enable_writeback=1, reset=0 and sr1==dr, VSR1 = wb_value in the same cycle (write-through forwarding).
  - Same rule applies independently to VSR2 with sr2.
  - psr is unaffected by the bypass; it remains registered.
- Undefined: pure register-file reads as described in Behaviour, with no forwarding path. The expected-value model is selected by the same macro.

Test Plan:
- Reset: hold reset 2 cycles with R3 previously written to 16'h1234 -> all R=0, psr=3'b000. With sr1=3, VSR1=16'h0000 after release.
- Source select with enable=1, dr=5, aluout=16'h0011, memout=16'h8000, pcout=16'h3000, npc_in=16'h3001:
  - W_Control_in=0/1/2/3 on four consecutive cycles -> R5 = 0011, 8000, 3000, 3001 in turn.
  - psr = 001, 100, 001, 001.
  - VSR1 (sr1=5) lags by 1 cycle.
- Zero result: W_Control_in=0, aluout=16'h0000, dr=0 -> R0=0, psr=3'b010.
- Disabled: enable_writeback=0, dr=2, aluout=16'hFFFF -> R2 and psr unchanged.
- Read/write same cycle: enable=1, dr=sr1=sr2=7, aluout=16'hABCD with R7=16'h0001:
  - Macro undefined -> VSR1=VSR2=16'h0001 that cycle, 16'hABCD next cycle.
  - LC3_WB_BYPASS_EN defined -> 16'hABCD in the same cycle.
- Reset vs write: reset=1 with enable=1, dr=4, aluout=16'h5555 -> R4=0, psr=PSR_RST.
